// File: rtl/jet_score_argmax_if.sv
// Score-collection and result handshake bundle for the jet class-score argmax block.
// The master side produces scores and consumes the result; the slave side is the argmax engine.
interface jet_score_argmax_if #(
    parameter int WIDTH       = 16,
    parameter int NUM_CLASSES = 5,
    parameter int IDX_W       = 3,
    parameter int CNT_W       = 16
);
    logic [NUM_CLASSES*WIDTH-1:0] score_in;
    logic [NUM_CLASSES-1:0]       score_vld;
    logic                         clear_err;
    logic                         result_valid;
    logic                         result_ready;
    logic [IDX_W-1:0]             class_idx;
    logic [WIDTH-1:0]             class_score;
    logic                         busy;
    logic                         dup_err;
    logic                         overrun;
    logic [CNT_W-1:0]             frame_cnt;

    modport master (
        output score_in, score_vld, clear_err, result_ready,
        input  result_valid, class_idx, class_score, busy, dup_err, overrun, frame_cnt
    );

    modport slave (
        input  score_in, score_vld, clear_err, result_ready,
        output result_valid, class_idx, class_score, busy, dup_err, overrun, frame_cnt
    );
endinterface

// File: rtl/jet_score_argmax.sv
// Collects per-class signed scores in any order, then scans them one compare per cycle
// and presents {class index, max score} on a valid/ready handshake.
module jet_score_argmax #(
    parameter int WIDTH       = 16,
    parameter int NUM_CLASSES = 5,
    parameter int IDX_W       = 3,
    parameter int CNT_W       = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    jet_score_argmax_if.slave  bus
);
    typedef enum logic [1:0] {COLLECT, SCAN, OUT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                 state_reg;
    logic [WIDTH-1:0]       slot_reg [NUM_CLASSES];
    logic [WIDTH-1:0]       score_slice [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] got_reg;
    logic [NUM_CLASSES-1:0] fill;
    logic [NUM_CLASSES-1:0] got_next;
    logic [IDX_W-1:0]       k_reg;
    logic [IDX_W-1:0]       best_idx_reg;
    logic [WIDTH-1:0]       best_reg;
    logic [WIDTH-1:0]       best_entry;
    logic                   result_valid_reg;
    logic                   dup_err_reg;
    logic                   overrun_reg;
    logic [CNT_W-1:0]       frame_cnt_reg;
    logic                   collect;
    logic                   accept;
    logic                   dup_hit;
    logic                   overrun_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_slice
            assign score_slice[gi] = bus.score_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign collect     = (state_reg == COLLECT);
    assign accept      = result_valid_reg & bus.result_ready;
    assign fill        = collect ? (bus.score_vld & ~got_reg) : '0;
    assign got_next    = got_reg | fill;
    assign dup_hit     = collect & (|(bus.score_vld & got_reg));
    assign overrun_hit = ~collect & (|bus.score_vld);
    // Slot 0 may be filling in the very cycle the frame completes, so seed from the incoming value.
    assign best_entry  = fill[0] ? score_slice[0] : slot_reg[0];

    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            got_reg <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                slot_reg[i] <= '0;
            end
        end else if (accept) begin
            got_reg <= '0;
        end else begin
            got_reg <= got_next;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (fill[i]) begin
                    slot_reg[i] <= score_slice[i];
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            state_reg        <= COLLECT;
            k_reg            <= '0;
            best_idx_reg     <= '0;
            best_reg         <= '0;
            result_valid_reg <= 1'b0;
            dup_err_reg      <= 1'b0;
            overrun_reg      <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            // Set events take priority over the clear request.
            if (dup_hit) begin
                dup_err_reg <= 1'b1;
            end else if (bus.clear_err) begin
                dup_err_reg <= 1'b0;
            end
            if (overrun_hit) begin
                overrun_reg <= 1'b1;
            end else if (bus.clear_err) begin
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                COLLECT: begin
                    if (&got_next) begin
                        state_reg    <= SCAN;
                        best_reg     <= best_entry;
                        best_idx_reg <= '0;
                        k_reg        <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    if ($signed(slot_reg[k_reg]) > $signed(best_reg)) begin
                        best_reg     <= slot_reg[k_reg];
                        best_idx_reg <= k_reg;
                    end
                    if (k_reg == LAST_IDX) begin
                        state_reg        <= OUT;
                        result_valid_reg <= 1'b1;
                    end
                    k_reg <= k_reg + IDX_W'(1);
                end
                OUT: begin
                    if (accept) begin
                        state_reg        <= COLLECT;
                        result_valid_reg <= 1'b0;
                        frame_cnt_reg    <= frame_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= COLLECT;
                end
            endcase
        end
    end

    assign bus.result_valid = result_valid_reg;
    assign bus.class_idx    = best_idx_reg;
    assign bus.class_score  = best_reg;
    assign bus.busy         = (state_reg != COLLECT);
    assign bus.dup_err      = dup_err_reg;
    assign bus.overrun      = overrun_reg;
    assign bus.frame_cnt    = frame_cnt_reg;
endmodule

// File: tb/tb_jet_score_argmax.sv
// Directed bench for jet_score_argmax: latency, argmax/tie/negative cases, backpressure,
// sticky error flags, async reset abort and frame-counter wrap on a narrow-counter instance.
module tb_jet_score_argmax;
    logic ap_clk;
    logic ap_rst;
    int   n_cmp;
    int   n_bad;
    int   exp_cnt;

    jet_score_argmax_if #(.WIDTH(16), .NUM_CLASSES(5), .IDX_W(3), .CNT_W(16)) bus ();
    jet_score_argmax_if #(.WIDTH(16), .NUM_CLASSES(5), .IDX_W(3), .CNT_W(3))  sbus ();

    jet_score_argmax #(.WIDTH(16), .NUM_CLASSES(5), .IDX_W(3), .CNT_W(16)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    jet_score_argmax #(.WIDTH(16), .NUM_CLASSES(5), .IDX_W(3), .CNT_W(3)) dut_wrap (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (sbus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called with the final strobe already driven; samples it, then waits for the result.
    task automatic wait_result(input logic [2:0] eidx, input logic [15:0] esc, input string tag);
        int lat;
        tick();
        bus.score_vld = '0;
        lat = 1;
        while (!bus.result_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 5);
        chk({tag, "_idx"}, {29'd0, bus.class_idx}, {29'd0, eidx});
        chk({tag, "_score"}, {16'd0, bus.class_score}, {16'd0, esc});
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic accept_result(input string tag);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_valid_drop"}, {31'd0, bus.result_valid}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_frame_cnt"}, {16'd0, bus.frame_cnt}, exp_cnt);
    endtask

    initial begin
        logic [79:0] pk;
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 0;
        ap_rst  = 1'b0;
        bus.score_in      = '0;
        bus.score_vld     = '0;
        bus.clear_err     = 1'b0;
        bus.result_ready  = 1'b0;
        sbus.score_in     = '0;
        sbus.score_vld    = '0;
        sbus.clear_err    = 1'b0;
        sbus.result_ready = 1'b0;
        #2;
        chk("rst_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("rst_idx", {29'd0, bus.class_idx}, 32'd0);
        chk("rst_score", {16'd0, bus.class_score}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_flags", {30'd0, bus.dup_err, bus.overrun}, 32'd0);
        chk("rst_cnt", {16'd0, bus.frame_cnt}, 32'd0);
        chk("rst_wrap_cnt", {29'd0, sbus.frame_cnt}, 32'd0);
        tick();
        tick();
        ap_rst = 1'b1;

        // Frame 1: all strobes together, max at slot 2
        bus.score_in  = {16'h0000, 16'h0200, 16'h0400, 16'hFC00, 16'h0100};
        bus.score_vld = 5'b11111;
        wait_result(3'd2, 16'h0400, "t1");
        accept_result("t1");

        // Frame 2a: all equal, lowest index wins
        bus.score_in  = {16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200};
        bus.score_vld = 5'b11111;
        wait_result(3'd0, 16'h0200, "t2_tie");
        accept_result("t2_tie");

        // Frame 2b: all negative
        bus.score_in  = {16'hFA00, 16'hFF00, 16'hF800, 16'hFE00, 16'hFC00};
        bus.score_vld = 5'b11111;
        wait_result(3'd3, 16'hFF00, "t2_neg");
        accept_result("t2_neg");

        // Frame 3: staggered strobes 4,0,3,1,2 with gaps; equal max on slots 1 and 3
        bus.score_in  = {16'hFFFF, 16'h0500, 16'h0123, 16'h0500, 16'h0010};
        bus.score_vld = 5'b10000; tick(); bus.score_vld = '0; tick();
        bus.score_vld = 5'b00001; tick(); bus.score_vld = '0; tick();
        bus.score_vld = 5'b01000; tick(); bus.score_vld = '0; tick();
        bus.score_vld = 5'b00010; tick(); bus.score_vld = '0; tick();
        chk("t3_collect_busy", {31'd0, bus.busy}, 32'd0);
        chk("t3_collect_valid", {31'd0, bus.result_valid}, 32'd0);
        bus.score_vld = 5'b00100;
        wait_result(3'd1, 16'h0500, "t3");
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t3_hold_valid", {31'd0, bus.result_valid}, 32'd1);
            chk("t3_hold_idx", {29'd0, bus.class_idx}, 32'd1);
            chk("t3_hold_score", {16'd0, bus.class_score}, 32'h0500);
            chk("t3_hold_cnt", {16'd0, bus.frame_cnt}, exp_cnt);
        end
        accept_result("t3");

        // Frame 4: duplicate strobe on slot 1 keeps the first value
        bus.score_in  = {16'h0100, 16'h0100, 16'h0100, 16'h0300, 16'h0100};
        bus.score_vld = 5'b00010; tick(); bus.score_vld = '0;
        chk("t4_no_dup_yet", {31'd0, bus.dup_err}, 32'd0);
        bus.score_in  = {16'h0100, 16'h0100, 16'h0100, 16'h7FFF, 16'h0100};
        bus.score_vld = 5'b00010; tick(); bus.score_vld = '0;
        chk("t4_dup_err", {31'd0, bus.dup_err}, 32'd1);
        bus.score_vld = 5'b11101;
        wait_result(3'd1, 16'h0300, "t4");
        bus.score_in  = {5{16'h7FFF}};
        bus.score_vld = 5'b11111; tick(); bus.score_vld = '0;
        chk("t4_overrun", {31'd0, bus.overrun}, 32'd1);
        chk("t4_ovr_valid", {31'd0, bus.result_valid}, 32'd1);
        chk("t4_ovr_idx", {29'd0, bus.class_idx}, 32'd1);
        chk("t4_ovr_score", {16'd0, bus.class_score}, 32'h0300);
        accept_result("t4");
        bus.clear_err = 1'b1; tick(); bus.clear_err = 1'b0;
        chk("t4_clear_dup", {31'd0, bus.dup_err}, 32'd0);
        chk("t4_clear_ovr", {31'd0, bus.overrun}, 32'd0);

        // Frame 4b: clear_err coincident with a new duplicate
        bus.score_in  = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
        bus.score_vld = 5'b00001; tick();
        bus.score_in  = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
        bus.clear_err = 1'b1; tick();
        bus.clear_err = 1'b0; bus.score_vld = '0;
        chk("t4_set_wins", {31'd0, bus.dup_err}, 32'd1);
        bus.score_vld = 5'b11110;
        wait_result(3'd0, 16'h0001, "t4b");
        accept_result("t4b");

        // Frame 5: reset pulse during SCAN aborts the frame
        bus.score_in  = {16'h0000, 16'h0200, 16'h0400, 16'hFC00, 16'h0100};
        bus.score_vld = 5'b11111; tick(); bus.score_vld = '0;
        tick();
        chk("t5_in_scan", {31'd0, bus.busy}, 32'd1);
        ap_rst = 1'b0;
        #1;
        exp_cnt = 0;
        chk("t5_rst_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_rst_idx", {29'd0, bus.class_idx}, 32'd0);
        chk("t5_rst_score", {16'd0, bus.class_score}, 32'd0);
        chk("t5_rst_flags", {30'd0, bus.dup_err, bus.overrun}, 32'd0);
        chk("t5_rst_cnt", {16'd0, bus.frame_cnt}, 32'd0);
        tick();
        ap_rst = 1'b1;
        bus.score_in  = {16'h0000, 16'h0001, 16'h8000, 16'h7FFF, 16'h0010};
        bus.score_vld = 5'b11111;
        wait_result(3'd1, 16'h7FFF, "t5");
        accept_result("t5");

        // Frame 6: back-to-back frames, sink always ready, counter wraps mod 8
        sbus.result_ready = 1'b1;
        for (int f = 0; f < 9; f++) begin
            int lat;
            int vcount;
            for (int i = 0; i < 5; i++) begin
                pk[i*16 +: 16] = (i == f % 5) ? (16'h0300 + 16'(f)) : (16'hFF00 - 16'(i));
            end
            sbus.score_in  = pk;
            sbus.score_vld = 5'b11111;
            tick();
            sbus.score_vld = '0;
            lat = 1;
            while (!sbus.result_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk("t6_latency", lat, 5);
            chk("t6_idx", {29'd0, sbus.class_idx}, f % 5);
            chk("t6_score", {16'd0, sbus.class_score}, 32'h0300 + f);
            vcount = 0;
            for (int c = 0; c < 3; c++) begin
                if (sbus.result_valid) vcount++;
                tick();
            end
            chk("t6_single_valid", vcount, 1);
            chk("t6_cnt", {29'd0, sbus.frame_cnt}, (f + 1) % 8);
        end
        sbus.result_ready = 1'b0;
        chk("t6_wrap_to_1", {29'd0, sbus.frame_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
